// File: rtl/eth_tx_frame_arbiter_if.sv
// AXI-stream bundle carrying LANES parallel channels that share one packed tdata vector.
// Lane i data sits at tdata[i*DATA_WIDTH +: DATA_WIDTH]; tready flows opposite to the payload.
interface eth_tx_frame_arbiter_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 8
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
    logic [LANES-1:0]            tlast;
    logic [LANES-1:0]            tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-atomic round-robin arbiter feeding one MAC AXI-stream TX port through a 2-entry skid buffer.
// Define ETH_TX_ARB_WATCHDOG_EN to add the mid-frame stall watchdog (abort beat + DRAIN state).
module eth_tx_frame_arbiter #(
    parameter  int S_COUNT        = 2,
    parameter  int DATA_WIDTH     = 8,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W          = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    eth_tx_frame_arbiter_if.slave  s_axis,
    eth_tx_frame_arbiter_if.master m_axis,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic                   abort
);

    if (S_COUNT < 2 || S_COUNT > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("eth_tx_frame_arbiter: S_COUNT must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam logic [1:0] ST_DRAIN  = 2'd2;
`endif

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic                  user;
    } beat_t;

    logic [1:0]            state;
    logic [1:0]            skid_cnt;
    logic                  skid_full;
    beat_t                 head;
    beat_t                 tail;
    beat_t                 push_beat;

    logic                  g_valid;
    logic                  g_last;
    logic                  g_user;
    logic [DATA_WIDTH-1:0] g_data;

    logic                  any_req;
    logic [IDX_W-1:0]      next_grant;
    logic [IDX_W-1:0]      cand;
    logic                  s_ready_g;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  timeout;
    logic                  wd_fire;

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= S_COUNT) sum = sum - S_COUNT;
        return IDX_W'(sum);
    endfunction

    assign g_valid = s_axis.tvalid[grant_idx];
    assign g_last  = s_axis.tlast[grant_idx];
    assign g_user  = s_axis.tuser[grant_idx];
    assign g_data  = s_axis.tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];

    // Scan from grant_idx+S_COUNT down to grant_idx+1 so the nearest requester after the last grant wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        any_req    = 1'b0;
        next_grant = grant_idx;
        cand       = grant_idx;
        for (int k = S_COUNT; k >= 1; k--) begin
            cand = wrap_idx(grant_idx, k);
            if (s_axis.tvalid[cand]) begin
                any_req    = 1'b1;
                next_grant = cand;
            end
        end
    end

    always_comb begin
        s_ready_g = 1'b0;
        case (state)
            ST_ACTIVE: s_ready_g = ~skid_full & ~timeout;
`ifdef ETH_TX_ARB_WATCHDOG_EN
            ST_DRAIN:  s_ready_g = 1'b1;
`endif
            default:   s_ready_g = 1'b0;
        endcase
    end

    assign s_axis.tready = s_ready_g ? (S_COUNT'(1) << grant_idx) : '0;
    assign accept        = g_valid & s_ready_g;
    assign push          = (accept & (state == ST_ACTIVE)) | wd_fire;
    assign pop           = m_axis.tvalid[0] & m_axis.tready[0];
    assign skid_full     = (skid_cnt == 2'd2);
    assign busy          = (state != ST_IDLE);

    // The watchdog's abort beat replaces source data with an empty, bad-flagged end of frame.
    assign push_beat.data = wd_fire ? '0 : g_data;
    assign push_beat.last = wd_fire | g_last;
    assign push_beat.user = wd_fire | g_user;

    assign m_axis.tvalid = (skid_cnt != 2'd0);
    assign m_axis.tdata  = head.data;
    assign m_axis.tlast  = head.last;
    assign m_axis.tuser  = head.user;

    // NOTE: flops use non-blocking (<=) so each one samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_idx <= IDX_W'(S_COUNT - 1);
            skid_cnt  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   skid_cnt <= skid_cnt + 2'd1;
                2'b01:   skid_cnt <= skid_cnt - 2'd1;
                default: skid_cnt <= skid_cnt;
            endcase
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant_idx <= next_grant;
                        state     <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (accept && g_last) state <= ST_IDLE;
`ifdef ETH_TX_ARB_WATCHDOG_EN
                    else if (wd_fire)     state <= ST_DRAIN;
`endif
                end
`ifdef ETH_TX_ARB_WATCHDOG_EN
                ST_DRAIN: begin
                    if (accept && g_last) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: payload registers carry no reset; validity lives entirely in skid_cnt.
    always_ff @(posedge clk) begin
        if (push && (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && pop))) begin
            head <= push_beat;
        end else if (pop && skid_cnt == 2'd2) begin
            head <= tail;
        end
        if (push && skid_cnt == 2'd1 && !pop) begin
            tail <= push_beat;
        end
    end

`ifdef ETH_TX_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] stall_cnt;

    assign timeout = (stall_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign wd_fire = (state == ST_ACTIVE) & timeout & ~skid_full;

    // Counts only cycles where the granted source withholds tvalid; a full skid is not a source stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            abort     <= 1'b0;
        end else begin
            abort <= wd_fire;
            if (state != ST_ACTIVE || accept) begin
                stall_cnt <= '0;
            end else if (!g_valid && !timeout) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign wd_fire = 1'b0;
    assign abort   = 1'b0;
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Directed bench for eth_tx_frame_arbiter with S_COUNT=2, DATA_WIDTH=8, TIMEOUT_CYCLES=16.
// The stall-watchdog scenario is compiled in only when ETH_TX_ARB_WATCHDOG_EN is defined.
module tb_eth_tx_frame_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] grant_idx;
    logic       busy;
    logic       abort;

    eth_tx_frame_arbiter_if #(.LANES(2), .DATA_WIDTH(8)) s_if ();
    eth_tx_frame_arbiter_if #(.LANES(1), .DATA_WIDTH(8)) m_if ();

    eth_tx_frame_arbiter #(
        .S_COUNT(2),
        .DATA_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis(s_if),
        .m_axis(m_if),
        .grant_idx(grant_idx),
        .busy(busy),
        .abort(abort)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   occ       = 0;
    int   abort_cnt = 0;
    logic in_frame0    = 1'b0;
    logic ready_chk_en = 1'b0;
    logic t3_done      = 1'b0;

    logic [9:0] mon_q[$];
    int         mon_cyc_q[$];
    int         acc_cyc_q[$];
    logic       rdy_obs_q[$];
    logic       rdy_exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] beat(input logic user, input logic last, input logic [7:0] data);
        return {user, last, data};
    endfunction

    // Output monitor plus a bench-side skid occupancy model built from observed handshakes.
    always @(negedge clk) begin
        if (rst) begin
            occ       <= 0;
            in_frame0 <= 1'b0;
        end else begin
            if (m_if.tvalid[0] && m_if.tready[0]) begin
                mon_q.push_back({m_if.tuser[0], m_if.tlast[0], m_if.tdata});
                mon_cyc_q.push_back(cyc);
            end
            if (abort) abort_cnt <= abort_cnt + 1;
            if (ready_chk_en && in_frame0) begin
                rdy_obs_q.push_back(s_if.tready[0]);
                rdy_exp_q.push_back(occ != 2);
            end
            occ <= occ + ((|(s_if.tvalid & s_if.tready)) ? 1 : 0)
                       - ((m_if.tvalid[0] && m_if.tready[0]) ? 1 : 0);
            if (s_if.tvalid[0] && s_if.tready[0]) in_frame0 <= ~s_if.tlast[0];
        end
    end

    // Presents len beats base, base+1, ...; optionally drops tvalid for gap_len cycles before beat gap_at.
    task automatic send_frame(input logic src, input logic [7:0] base, input int len,
                              input int gap_at, input int gap_len);
        int waited;
        for (int i = 0; i < len; i++) begin
            if (i == gap_at) begin
                s_if.tvalid[src] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            s_if.tdata[{src, 3'b000} +: 8] = base + 8'(i);
            s_if.tlast[src]  = (i == len - 1);
            s_if.tuser[src]  = 1'b0;
            s_if.tvalid[src] = 1'b1;
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!s_if.tready[src] && waited < 200);
            if (!s_if.tready[src]) begin
                check("src_accept_timeout", 32'(s_if.tready[src]), 32'd1);
                s_if.tvalid[src] = 1'b0;
                return;
            end
            acc_cyc_q.push_back(cyc);
            @(posedge clk);
            #1;
        end
        s_if.tvalid[src] = 1'b0;
        s_if.tlast[src]  = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [9:0] exp);
        if (mon_q.size() == 0) check({tag, "_missing"}, 32'd0, 32'd1);
        else                   check(tag, 32'(mon_q.pop_front()), 32'(exp));
    endtask

    task automatic settle();
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: time %0t exceeded limit 300000", $time);
        $fatal(1, "bench time limit reached");
    end

    initial begin
        s_if.tvalid = '0;
        s_if.tlast  = '0;
        s_if.tuser  = '0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("rst_m_tvalid", 32'(m_if.tvalid[0]), 32'd0);
        check("rst_s_tready", 32'(s_if.tready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_abort", 32'(abort), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd1);
        @(posedge clk);
        #1;

        // T1: 4-beat frame from req0, one cycle accept-to-output latency.
        mon_q.delete(); mon_cyc_q.delete(); acc_cyc_q.delete();
        send_frame(1'b0, 8'h01, 4, -1, 0);
        settle();
        check("t1_grant_idx", 32'(grant_idx), 32'd0);
        check("t1_acc_count", 32'(acc_cyc_q.size()), 32'd4);
        check("t1_mon_count", 32'(mon_cyc_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < mon_cyc_q.size() && i < acc_cyc_q.size(); i++)
            check($sformatf("t1_latency%0d", i), 32'(mon_cyc_q[i] - acc_cyc_q[i]), 32'd1);
        expect_beat("t1_beat0", beat(1'b0, 1'b0, 8'h01));
        expect_beat("t1_beat1", beat(1'b0, 1'b0, 8'h02));
        expect_beat("t1_beat2", beat(1'b0, 1'b0, 8'h03));
        expect_beat("t1_beat3", beat(1'b0, 1'b1, 8'h04));
        check("t1_extra", 32'(mon_q.size()), 32'd0);

        // T2: simultaneous requests after reset, two rounds -> A,B,A,B with no interleave.
        do_reset();
        mon_q.delete();
        for (int r = 0; r < 2; r++) begin
            fork
                send_frame(1'b0, 8'hA0, 3, -1, 0);
                send_frame(1'b1, 8'hB0, 2, -1, 0);
            join
        end
        settle();
        for (int r = 0; r < 2; r++) begin
            expect_beat($sformatf("t2_r%0d_a0", r), beat(1'b0, 1'b0, 8'hA0));
            expect_beat($sformatf("t2_r%0d_a1", r), beat(1'b0, 1'b0, 8'hA1));
            expect_beat($sformatf("t2_r%0d_a2", r), beat(1'b0, 1'b1, 8'hA2));
            expect_beat($sformatf("t2_r%0d_b0", r), beat(1'b0, 1'b0, 8'hB0));
            expect_beat($sformatf("t2_r%0d_b1", r), beat(1'b0, 1'b1, 8'hB1));
        end
        check("t2_extra", 32'(mon_q.size()), 32'd0);

        // T3: MAC ready toggles 1,0,0,1 during a 6-beat frame.
        mon_q.delete(); rdy_obs_q.delete(); rdy_exp_q.delete();
        ready_chk_en = 1'b1;
        t3_done      = 1'b0;
        fork
            begin
                send_frame(1'b0, 8'h30, 6, -1, 0);
                t3_done = 1'b1;
            end
            begin
                logic [3:0] pat;
                int k;
                pat = 4'b1001;
                k   = 0;
                while (!t3_done) begin
                    m_if.tready = pat[k % 4];
                    k++;
                    @(posedge clk);
                    #1;
                end
            end
        join
        ready_chk_en = 1'b0;
        m_if.tready  = 1'b1;
        settle();
        begin
            int lows;
            lows = 0;
            while (rdy_obs_q.size() > 0 && rdy_exp_q.size() > 0) begin
                if (!rdy_obs_q[0]) lows++;
                check("t3_s_ready_vs_skid", 32'(rdy_obs_q.pop_front()), 32'(rdy_exp_q.pop_front()));
            end
            check("t3_saw_backpressure", 32'(lows > 0), 32'd1);
        end
        for (int i = 0; i < 6; i++)
            expect_beat($sformatf("t3_beat%0d", i), beat(1'b0, i == 5, 8'h30 + 8'(i)));
        check("t3_extra", 32'(mon_q.size()), 32'd0);

        // T4: single-beat frame from req1 while req0 idle.
        mon_q.delete();
        send_frame(1'b1, 8'hAA, 1, -1, 0);
        @(negedge clk);
        check("t4_busy_after", 32'(busy), 32'd0);
        check("t4_grant_idx", 32'(grant_idx), 32'd1);
        settle();
        expect_beat("t4_beat", beat(1'b0, 1'b1, 8'hAA));
        check("t4_extra", 32'(mon_q.size()), 32'd0);

        // T5: reset mid-frame with a full skid; skid contents are discarded.
        mon_q.delete();
        m_if.tready = 1'b0;
        s_if.tdata[7:0] = 8'h40;
        s_if.tlast[0]   = 1'b0;
        s_if.tuser[0]   = 1'b0;
        s_if.tvalid[0]  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("t5_prefill_ready", 32'(s_if.tready[0]), 32'd0);
        rst = 1'b1;
        s_if.tvalid[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_if.tready = 1'b1;
        fork
            send_frame(1'b0, 8'h50, 1, -1, 0);
            send_frame(1'b1, 8'h60, 1, -1, 0);
            begin
                @(negedge clk);
                check("t5_m_tvalid", 32'(m_if.tvalid[0]), 32'd0);
                check("t5_s_tready", 32'(s_if.tready), 32'd0);
                check("t5_busy", 32'(busy), 32'd0);
                @(negedge clk);
                check("t5_grant_idx", 32'(grant_idx), 32'd0);
            end
        join
        settle();
        expect_beat("t5_beat0", beat(1'b0, 1'b1, 8'h50));
        expect_beat("t5_beat1", beat(1'b0, 1'b1, 8'h60));
        check("t5_extra", 32'(mon_q.size()), 32'd0);

`ifdef ETH_TX_ARB_WATCHDOG_EN
        // T6: req0 stalls 16 cycles mid-frame -> abort beat, rest of frame drained, req1 next.
        mon_q.delete();
        abort_cnt = 0;
        fork
            send_frame(1'b0, 8'h70, 5, 2, 16);
            send_frame(1'b1, 8'h80, 2, -1, 0);
        join
        settle();
        expect_beat("t6_beat0", beat(1'b0, 1'b0, 8'h70));
        expect_beat("t6_beat1", beat(1'b0, 1'b0, 8'h71));
        expect_beat("t6_abort_beat", beat(1'b1, 1'b1, 8'h00));
        expect_beat("t6_req1_beat0", beat(1'b0, 1'b0, 8'h80));
        expect_beat("t6_req1_beat1", beat(1'b0, 1'b1, 8'h81));
        check("t6_extra", 32'(mon_q.size()), 32'd0);
        check("t6_abort_count", 32'(abort_cnt), 32'd1);
        check("t6_grant_idx", 32'(grant_idx), 32'd1);
`else
        check("abort_count", 32'(abort_cnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
